// File: rtl/memory_pkg.sv
// Encodings shared by the cache/memory arbiter and its round-robin picker.
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_e;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a tie goes to whichever requester was not served last.
module rr_arbiter2
    import memory_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant_q == REQ_ICACHE) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_ICACHE;
        end else if (update && (grant != 2'b00)) begin
            last_grant_q <= grant[REQ_DCACHE];
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one line-wide main memory between the instruction and data caches,
// latching the winner's command and sequencing the memory handshake.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int ADDRESS_SIZE    = 12,
    parameter int CACHE_LINE_SIZE = 128
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       icache_req,
    input  logic                       icache_op,
    input  logic [ADDRESS_SIZE-1:0]    icache_address,
    input  logic [CACHE_LINE_SIZE-1:0] icache_data_in,
    output logic                       icache_ready,
    output logic [CACHE_LINE_SIZE-1:0] icache_data_out,

    input  logic                       dcache_req,
    input  logic                       dcache_op,
    input  logic [ADDRESS_SIZE-1:0]    dcache_address,
    input  logic [CACHE_LINE_SIZE-1:0] dcache_data_in,
    output logic                       dcache_ready,
    output logic [CACHE_LINE_SIZE-1:0] dcache_data_out,

    output logic                       mem_enable,
    output logic                       mem_op,
    output logic [ADDRESS_SIZE-1:0]    mem_address,
    output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
    output logic                       mem_op_init,
    output logic                       mem_op_done,
    input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
    input  logic                       mem_data_ready
);

    arb_state_e                 state_q;
    logic                       winner_q;
    logic                       op_q;
    logic [ADDRESS_SIZE-1:0]    addr_q;
    logic [CACHE_LINE_SIZE-1:0] wdata_q;
    logic                       op_init_q;
    logic                       op_done_q;
    logic                       icache_ready_q;
    logic                       dcache_ready_q;
    logic [CACHE_LINE_SIZE-1:0] icache_rdata_q;
    logic [CACHE_LINE_SIZE-1:0] dcache_rdata_q;

    logic [1:0]                 req;
    logic [1:0]                 grant;
    logic                       can_grant;
    logic                       cmd_op_d;
    logic [ADDRESS_SIZE-1:0]    cmd_addr_d;
    logic [CACHE_LINE_SIZE-1:0] cmd_data_d;

    assign req = {dcache_req, icache_req};

    // DONE may hand straight over to the next requester; the data_ready still
    // visible then is our own result, already being retired by mem_op_done.
    assign can_grant = ((state_q == IDLE) && !mem_data_ready) || (state_q == DONE);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (can_grant),
        .grant  (grant)
    );

    always_comb begin
        cmd_op_d   = icache_op;
        cmd_addr_d = icache_address;
        cmd_data_d = icache_data_in;
        if (grant[REQ_DCACHE]) begin
            cmd_op_d   = dcache_op;
            cmd_addr_d = dcache_address;
            cmd_data_d = dcache_data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            winner_q       <= REQ_ICACHE;
            op_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            op_init_q      <= 1'b0;
            op_done_q      <= 1'b0;
            icache_ready_q <= 1'b0;
            dcache_ready_q <= 1'b0;
            icache_rdata_q <= '0;
            dcache_rdata_q <= '0;
        end else begin
            op_init_q      <= 1'b0;
            op_done_q      <= 1'b0;
            icache_ready_q <= 1'b0;
            dcache_ready_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (!can_grant) begin
                        // Result orphaned by a reset: retire it before granting anyone.
                        op_done_q <= 1'b1;
                    end else if (grant != 2'b00) begin
                        state_q   <= BUSY;
                        winner_q  <= grant[REQ_DCACHE];
                        op_q      <= cmd_op_d;
                        addr_q    <= cmd_addr_d;
                        wdata_q   <= cmd_data_d;
                        op_init_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_data_ready) begin
                        if (winner_q == REQ_DCACHE) begin
                            dcache_rdata_q <= mem_data_out;
                            dcache_ready_q <= 1'b1;
                        end else begin
                            icache_rdata_q <= mem_data_out;
                            icache_ready_q <= 1'b1;
                        end
                        op_done_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Combinational so memory never sees enable alongside its own result.
    assign mem_enable      = (state_q == BUSY) && !mem_data_ready;
    assign mem_op          = op_q;
    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;
    assign mem_op_init     = op_init_q;
    assign mem_op_done     = op_done_q;
    assign icache_ready    = icache_ready_q;
    assign dcache_ready    = dcache_ready_q;
    assign icache_data_out = icache_rdata_q;
    assign dcache_data_out = dcache_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a behavioural line memory with OP_DELAY_CYCLES=3 and
// a reference model that serves requests in round-robin order on a shadow memory.
`timescale 1ns/1ps
module tb_memory_arbiter;
    import memory_pkg::*;

    localparam int AW = 12;
    localparam int LW = 128;
    localparam int D  = 3;
    typedef logic [LW-1:0] line_t;

    logic          clk;
    logic          reset;
    logic          icache_req, icache_op, dcache_req, dcache_op;
    logic [AW-1:0] icache_address, dcache_address;
    line_t         icache_data_in, dcache_data_in;
    logic          icache_ready, dcache_ready;
    line_t         icache_data_out, dcache_data_out;
    logic          mem_enable, mem_op, mem_op_init, mem_op_done, mem_data_ready;
    logic [AW-1:0] mem_address;
    line_t         mem_data_in, mem_data_out;

    int checks = 0;
    int errors = 0;
    bit model_last;
    logic [7:0] mem     [0:4095];
    logic [7:0] ref_mem [0:4095];

    memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW)) dut (
        .clk(clk), .reset(reset),
        .icache_req(icache_req), .icache_op(icache_op), .icache_address(icache_address),
        .icache_data_in(icache_data_in), .icache_ready(icache_ready), .icache_data_out(icache_data_out),
        .dcache_req(dcache_req), .dcache_op(dcache_op), .dcache_address(dcache_address),
        .dcache_data_in(dcache_data_in), .dcache_ready(dcache_ready), .dcache_data_out(dcache_data_out),
        .mem_enable(mem_enable), .mem_op(mem_op), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_op_init(mem_op_init), .mem_op_done(mem_op_done), .mem_data_out(mem_data_out),
        .mem_data_ready(mem_data_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic line_t mem_line(input logic [AW-1:0] a);
        line_t l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = mem[AW'(a + k)];
        return l;
    endfunction

    function automatic line_t ref_line(input logic [AW-1:0] a);
        line_t l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = ref_mem[AW'(a + k)];
        return l;
    endfunction

    // Memory: starts on op_init, result ready D+1 edges later, held until op_done.
    initial begin : memory_model
        bit            busy;
        int            cnt;
        logic          m_op;
        logic [AW-1:0] m_addr;
        line_t         m_wdata;
        busy = 1'b0; cnt = 0; m_op = 1'b0; m_addr = '0; m_wdata = '0;
        mem_data_ready = 1'b0;
        mem_data_out   = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        forever begin
            @(posedge clk);
            if (mem_op_done) mem_data_ready <= 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0;
                    mem_data_ready <= 1'b1;
                    if (m_op == OP_WRITE) begin
                        for (int k = 0; k < 16; k++) mem[AW'(m_addr + k)] = m_wdata[8*k +: 8];
                        mem_data_out <= m_wdata;
                    end else begin
                        mem_data_out <= mem_line(m_addr);
                    end
                end else begin
                    cnt--;
                end
            end
            if (mem_op_init && mem_enable) begin
                busy = 1'b1; cnt = D; m_op = mem_op; m_addr = mem_address; m_wdata = mem_data_in;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_serve(input bit op, input logic [AW-1:0] a, input line_t wd, output line_t rd);
        if (op == OP_WRITE) begin
            for (int k = 0; k < 16; k++) ref_mem[AW'(a + k)] = wd[8*k +: 8];
            rd = wd;
        end else begin
            rd = ref_line(a);
        end
    endtask

    // Requests raised together: winner served first at D+3, the other one turn (D+4) later.
    task automatic model_pair(input bit ir, input bit iop, input logic [AW-1:0] ia, input line_t id,
                              input bit dr, input bit dop, input logic [AW-1:0] da, input line_t dd,
                              output int ei_cyc, output int ed_cyc, output line_t ei, output line_t ed);
        bit first;
        ei_cyc = -1; ed_cyc = -1; ei = '0; ed = '0;
        first = (ir && dr) ? ~model_last : dr;
        if (first == REQ_DCACHE) begin
            model_serve(dop, da, dd, ed); ed_cyc = D + 3;
            if (ir) begin model_serve(iop, ia, id, ei); ei_cyc = 2*D + 7; end
        end else begin
            model_serve(iop, ia, id, ei); ei_cyc = D + 3;
            if (dr) begin model_serve(dop, da, dd, ed); ed_cyc = 2*D + 7; end
        end
        model_last = (ir && dr) ? ~first : first;
    endtask

    // Acts as both caches: raise req, drop it once ready is seen, record what came back.
    task automatic run_pair(input bit ir, input bit iop, input logic [AW-1:0] ia, input line_t id,
                            input bit dr, input bit dop, input logic [AW-1:0] da, input line_t dd,
                            output int i_cyc, output int d_cyc, output int i_cnt, output int d_cnt,
                            output line_t i_out, output line_t d_out);
        i_cyc = -1; d_cyc = -1; i_cnt = 0; d_cnt = 0; i_out = '0; d_out = '0;
        icache_req = ir; icache_op = iop; icache_address = ia; icache_data_in = id;
        dcache_req = dr; dcache_op = dop; dcache_address = da; dcache_data_in = dd;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (icache_ready) begin
                i_cnt++;
                if (i_cyc < 0) begin i_cyc = c; i_out = icache_data_out; end
                icache_req = 1'b0;
            end
            if (dcache_ready) begin
                d_cnt++;
                if (d_cyc < 0) begin d_cyc = c; d_out = dcache_data_out; end
                dcache_req = 1'b0;
            end
        end
        icache_req = 1'b0; dcache_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++; if (icache_ready !== 1'b0) begin errors++; $display("FAIL rst_icache_ready got %b want 0", icache_ready); end
        checks++; if (dcache_ready !== 1'b0) begin errors++; $display("FAIL rst_dcache_ready got %b want 0", dcache_ready); end
        checks++; if (icache_data_out !== '0) begin errors++; $display("FAIL rst_icache_data got %h want 0", icache_data_out); end
        checks++; if (dcache_data_out !== '0) begin errors++; $display("FAIL rst_dcache_data got %h want 0", dcache_data_out); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL rst_mem_enable got %b want 0", mem_enable); end
        checks++; if (mem_op_init !== 1'b0) begin errors++; $display("FAIL rst_op_init got %b want 0", mem_op_init); end
        checks++; if (mem_op_done !== 1'b0) begin errors++; $display("FAIL rst_op_done got %b want 0", mem_op_done); end
        checks++; if (mem_address !== '0) begin errors++; $display("FAIL rst_mem_address got %h want 0", mem_address); end
        checks++; if (mem_data_in !== '0) begin errors++; $display("FAIL rst_mem_data_in got %h want 0", mem_data_in); end
        checks++; if (mem_op !== 1'b0) begin errors++; $display("FAIL rst_mem_op got %b want 0", mem_op); end
        reset = 1'b0;
        model_last = REQ_ICACHE;
        idle(1);
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL idle_mem_enable got %b want 0", mem_enable); end
    endtask

    task automatic test_single_read();
        int    ec_i, ec_d;
        line_t ei, ed, dprev;
        model_pair(1'b1, OP_READ, 12'h040, '0, 1'b0, OP_READ, '0, '0, ec_i, ec_d, ei, ed);
        dprev = dcache_data_out;
        icache_req = 1'b1; icache_op = OP_READ; icache_address = 12'h040; icache_data_in = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++; if (mem_op_init !== (c == 0)) begin errors++; $display("FAIL single_op_init E%0d got %b want %b", c, mem_op_init, (c == 0)); end
            checks++; if (mem_enable !== (c <= D + 1)) begin errors++; $display("FAIL single_enable E%0d got %b want %b", c, mem_enable, (c <= D + 1)); end
            checks++; if (icache_ready !== (c == ec_i)) begin errors++; $display("FAIL single_icache_ready E%0d got %b want %b", c, icache_ready, (c == ec_i)); end
            checks++; if (dcache_ready !== 1'b0) begin errors++; $display("FAIL single_dcache_ready E%0d got %b want 0", c, dcache_ready); end
            if (icache_ready) begin
                checks++; if (icache_data_out !== ei) begin errors++; $display("FAIL single_data got %h want %h", icache_data_out, ei); end
                icache_req = 1'b0;
            end
        end
        icache_req = 1'b0;
        checks++; if (dcache_data_out !== dprev) begin errors++; $display("FAIL single_loser_hold got %h want %h", dcache_data_out, dprev); end
    endtask

    task automatic test_simultaneous();
        int    ei_c, ed_c, i_c, d_c, i_n, d_n;
        line_t ei, ed, i_o, d_o;
        line_t wd;
        wd = 128'h00112233445566778899AABBCCDDEEFF;
        model_pair(1'b1, OP_READ, 12'h000, '0, 1'b1, OP_WRITE, 12'h100, wd, ei_c, ed_c, ei, ed);
        run_pair(1'b1, OP_READ, 12'h000, '0, 1'b1, OP_WRITE, 12'h100, wd, i_c, d_c, i_n, d_n, i_o, d_o);
        checks++; if (d_n !== 1) begin errors++; $display("FAIL simul_dcache_pulses got %0d want 1", d_n); end
        checks++; if (d_c !== ed_c) begin errors++; $display("FAIL simul_dcache_cycle got %0d want %0d", d_c, ed_c); end
        checks++; if (i_n !== 1) begin errors++; $display("FAIL simul_icache_pulses got %0d want 1", i_n); end
        checks++; if (i_c !== ei_c) begin errors++; $display("FAIL simul_icache_cycle got %0d want %0d", i_c, ei_c); end
        checks++; if (i_o !== ei) begin errors++; $display("FAIL simul_icache_data got %h want %h", i_o, ei); end
    endtask

    task automatic test_readback();
        int    ei_c, ed_c, i_c, d_c, i_n, d_n;
        line_t ei, ed, i_o, d_o;
        line_t wd;
        wd = 128'h00112233445566778899AABBCCDDEEFF;
        model_pair(1'b0, OP_READ, '0, '0, 1'b1, OP_READ, 12'h100, '0, ei_c, ed_c, ei, ed);
        run_pair(1'b0, OP_READ, '0, '0, 1'b1, OP_READ, 12'h100, '0, i_c, d_c, i_n, d_n, i_o, d_o);
        checks++; if (d_n !== 1 || d_c !== ed_c) begin errors++; $display("FAIL rb_dcache_timing got %0d@%0d want 1@%0d", d_n, d_c, ed_c); end
        checks++; if (d_o !== wd) begin errors++; $display("FAIL rb_dcache_data got %h want %h", d_o, wd); end
        checks++; if (d_o !== ed) begin errors++; $display("FAIL rb_dcache_model got %h want %h", d_o, ed); end
        model_pair(1'b1, OP_READ, 12'h100, '0, 1'b0, OP_READ, '0, '0, ei_c, ed_c, ei, ed);
        run_pair(1'b1, OP_READ, 12'h100, '0, 1'b0, OP_READ, '0, '0, i_c, d_c, i_n, d_n, i_o, d_o);
        checks++; if (i_n !== 1 || i_c !== ei_c) begin errors++; $display("FAIL rb_icache_timing got %0d@%0d want 1@%0d", i_n, i_c, ei_c); end
        checks++; if (i_o !== wd) begin errors++; $display("FAIL rb_icache_data got %h want %h", i_o, wd); end
    endtask

    task automatic test_alternate();
        int            n;
        bit            who, exp_who;
        logic [AW-1:0] ia, da;
        line_t         got, want;
        ia = 12'h300; da = 12'h310; n = 0;
        icache_req = 1'b1; icache_op = OP_READ; icache_address = ia; icache_data_in = '0;
        dcache_req = 1'b1; dcache_op = OP_READ; dcache_address = da; dcache_data_in = '0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(posedge clk); #1;
            if (icache_ready || dcache_ready) begin
                who = dcache_ready;
                exp_who = ~model_last;
                model_last = exp_who;
                checks++; if (who !== exp_who || (icache_ready && dcache_ready)) begin errors++; $display("FAIL alt_order #%0d got i=%b d=%b want dcache=%b", n, icache_ready, dcache_ready, exp_who); end
                checks++; if (c !== D + 3 + n * (D + 4)) begin errors++; $display("FAIL alt_cycle #%0d got %0d want %0d", n, c, D + 3 + n * (D + 4)); end
                got  = who ? dcache_data_out : icache_data_out;
                want = who ? ref_line(da) : ref_line(ia);
                checks++; if (got !== want) begin errors++; $display("FAIL alt_data #%0d got %h want %h", n, got, want); end
                n++;
            end
        end
        icache_req = 1'b0; dcache_req = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("FAIL alt_count got %0d want 3", n); end
        idle(4);
    endtask

    task automatic test_addr_change();
        int    ec_i, ec_d, n;
        line_t ei, ed;
        model_pair(1'b1, OP_READ, 12'h040, '0, 1'b0, OP_READ, '0, '0, ec_i, ec_d, ei, ed);
        n = 0;
        icache_req = 1'b1; icache_op = OP_READ; icache_address = 12'h040; icache_data_in = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                icache_address = 12'h080; icache_op = OP_WRITE;
                icache_data_in = {$urandom, $urandom, $urandom, $urandom};
            end
            if (c <= ec_i) begin
                checks++; if (mem_address !== 12'h040) begin errors++; $display("FAIL latch_address E%0d got %h want 040", c, mem_address); end
                checks++; if (mem_op !== OP_READ) begin errors++; $display("FAIL latch_op E%0d got %b want %b", c, mem_op, OP_READ); end
            end
            if (icache_ready) begin
                n++;
                checks++; if (icache_data_out !== ei) begin errors++; $display("FAIL latch_data got %h want %h", icache_data_out, ei); end
                icache_req = 1'b0;
            end
        end
        icache_req = 1'b0;
        checks++; if (n !== 1) begin errors++; $display("FAIL latch_pulses got %0d want 1", n); end
    endtask

    task automatic test_random();
        bit            ir, dr, iop, dop;
        logic [AW-1:0] ia, da;
        line_t         id, dd, ei, ed, i_o, d_o, iprev, dprev;
        int            ei_c, ed_c, i_c, d_c, i_n, d_n;
        for (int it = 0; it < 20; it++) begin
            ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            iop = 1'($urandom_range(0, 1)); dop = 1'($urandom_range(0, 1));
            ia = AW'(12'h200 + 16 * $urandom_range(0, 7));
            da = AW'(12'h200 + 16 * $urandom_range(0, 7));
            id = {$urandom, $urandom, $urandom, $urandom};
            dd = {$urandom, $urandom, $urandom, $urandom};
            iprev = icache_data_out; dprev = dcache_data_out;
            model_pair(ir, iop, ia, id, dr, dop, da, dd, ei_c, ed_c, ei, ed);
            run_pair(ir, iop, ia, id, dr, dop, da, dd, i_c, d_c, i_n, d_n, i_o, d_o);
            checks++; if (i_n !== int'(ir)) begin errors++; $display("FAIL rnd%0d_icache_pulses got %0d want %0d", it, i_n, ir); end
            checks++; if (d_n !== int'(dr)) begin errors++; $display("FAIL rnd%0d_dcache_pulses got %0d want %0d", it, d_n, dr); end
            if (ir) begin
                checks++; if (i_c !== ei_c) begin errors++; $display("FAIL rnd%0d_icache_cycle got %0d want %0d", it, i_c, ei_c); end
                if (iop == OP_READ) begin
                    checks++; if (i_o !== ei) begin errors++; $display("FAIL rnd%0d_icache_data got %h want %h", it, i_o, ei); end
                end
            end else begin
                checks++; if (icache_data_out !== iprev) begin errors++; $display("FAIL rnd%0d_icache_hold got %h want %h", it, icache_data_out, iprev); end
            end
            if (dr) begin
                checks++; if (d_c !== ed_c) begin errors++; $display("FAIL rnd%0d_dcache_cycle got %0d want %0d", it, d_c, ed_c); end
                if (dop == OP_READ) begin
                    checks++; if (d_o !== ed) begin errors++; $display("FAIL rnd%0d_dcache_data got %h want %h", it, d_o, ed); end
                end
            end else begin
                checks++; if (dcache_data_out !== dprev) begin errors++; $display("FAIL rnd%0d_dcache_hold got %h want %h", it, dcache_data_out, dprev); end
            end
        end
    endtask

    task automatic test_reset_busy();
        int    pulses, ec_i, ec_d;
        bit    seen_done, granted;
        line_t ei, ed, got;
        pulses = 0; seen_done = 1'b0; granted = 1'b0; got = '0;
        icache_req = 1'b1; icache_op = OP_READ; icache_address = 12'h040; icache_data_in = '0;
        idle(4);
        checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL rb_busy_enable got %b want 1", mem_enable); end
        reset = 1'b1; icache_req = 1'b0;
        #1;
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL rb_rst_enable got %b want 0", mem_enable); end
        checks++; if (mem_address !== '0) begin errors++; $display("FAIL rb_rst_address got %h want 0", mem_address); end
        checks++; if (mem_op_init !== 1'b0 || mem_op_done !== 1'b0) begin errors++; $display("FAIL rb_rst_init_done got %b%b want 00", mem_op_init, mem_op_done); end
        checks++; if (icache_data_out !== '0) begin errors++; $display("FAIL rb_rst_icache_data got %h want 0", icache_data_out); end
        checks++; if (dcache_data_out !== '0) begin errors++; $display("FAIL rb_rst_dcache_data got %h want 0", dcache_data_out); end
        checks++; if (icache_ready !== 1'b0 || dcache_ready !== 1'b0) begin errors++; $display("FAIL rb_rst_ready got %b%b want 00", icache_ready, dcache_ready); end
        #2;
        reset = 1'b0;
        model_last = REQ_ICACHE;
        for (int c = 0; c < 10 && !mem_data_ready; c++) begin
            @(posedge clk); #1;
            if (icache_ready || dcache_ready) pulses++;
        end
        checks++; if (mem_data_ready !== 1'b1) begin errors++; $display("FAIL rb_stale_result got %b want 1", mem_data_ready); end
        model_pair(1'b1, OP_READ, 12'h080, '0, 1'b0, OP_READ, '0, '0, ec_i, ec_d, ei, ed);
        icache_req = 1'b1; icache_op = OP_READ; icache_address = 12'h080;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (mem_op_done && !granted) seen_done = 1'b1;
            if (mem_op_init && !granted) begin
                granted = 1'b1;
                checks++; if (!seen_done) begin errors++; $display("FAIL rb_flush_first got op_done_seen=%b want 1", seen_done); end
            end
            if (icache_ready || dcache_ready) begin
                pulses++;
                got = icache_data_out;
                icache_req = 1'b0;
            end
        end
        icache_req = 1'b0;
        checks++; if (!granted) begin errors++; $display("FAIL rb_new_grant got %b want 1", granted); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL rb_pulses got %0d want 1", pulses); end
        checks++; if (got !== ei) begin errors++; $display("FAIL rb_new_data got %h want %h", got, ei); end
    endtask

    initial begin
        reset = 1'b1;
        icache_req = 1'b0; icache_op = OP_READ; icache_address = '0; icache_data_in = '0;
        dcache_req = 1'b0; dcache_op = OP_READ; dcache_address = '0; dcache_data_in = '0;
        model_last = REQ_ICACHE;
        #1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        test_reset();
        test_single_read();
        test_simultaneous();
        test_readback();
        test_alternate();
        test_addr_change();
        test_random();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
